// File: rtl/framebuf_wr_arb_pkg.sv
// Shared types for the framebuffer write arbiter: FSM states and grant codes.
package framebuf_wr_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } fb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_A    = 2'd1,
        GNT_B    = 2'd2
    } fb_grant_e;

endpackage

// File: rtl/fb_rr_arb2.sv
// Two-way round-robin arbiter. Grants are combinational from the requests,
// the enable and the stored priority. After any grant, priority moves to
// the other requester.
module fb_rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic req_a_i,
    input  logic req_b_i,
    input  logic enable_i,
    output logic gnt_a_o,
    output logic gnt_b_o
);

    // 0: A holds priority, 1: B holds priority
    logic prio_b_q, prio_b_d;

    // Priority register; reset hands priority to A
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_b_q <= 1'b0;
        end else begin
            prio_b_q <= prio_b_d;
        end
    end

    // Grant selection: a lone requester always wins, a tie goes to the priority holder
    always_comb begin
        gnt_a_o  = 1'b0;
        gnt_b_o  = 1'b0;
        prio_b_d = prio_b_q;
        if (enable_i) begin
            if (req_a_i && (!req_b_i || !prio_b_q)) begin
                gnt_a_o = 1'b1;
            end else if (req_b_i) begin
                gnt_b_o = 1'b1;
            end
        end
        if (gnt_a_o) begin
            prio_b_d = 1'b1;
        end else if (gnt_b_o) begin
            prio_b_d = 1'b0;
        end
    end

endmodule

// File: rtl/framebuf_wr_arb.sv
// Framebuffer write arbiter: round-robin between two pixel writers, an
// optional whole-buffer fill engine, and a never-stalling read port.
// The fill engine is built only when FRAMEBUF_WR_ARB_CLEAR_EN is defined;
// otherwise clr_start/clr_data are ignored and clr_busy/clr_done stay low.
module framebuf_wr_arb
    import framebuf_wr_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    input  logic                  clr_start,
    input  logic [DATA_WIDTH-1:0] clr_data,
    output logic                  clr_busy,
    output logic                  clr_done,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_valid,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr_w,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic [ADDR_WIDTH-1:0] ram_addr_r
);

    logic                  arb_en;
    logic                  gnt_a, gnt_b;
    fb_grant_e             grant;

    logic                  clr_wr;
    logic [ADDR_WIDTH-1:0] clr_wr_addr;
    logic [DATA_WIDTH-1:0] clr_wr_data;

    logic                  ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_w_q, ram_addr_w_d;
    logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;
    logic                  rd_valid_q;

    fb_rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .req_a_i  (a_valid),
        .req_b_i  (b_valid),
        .enable_i (arb_en),
        .gnt_a_o  (gnt_a),
        .gnt_b_o  (gnt_b)
    );

    // A grant is only ever issued to a valid requester, so ready==grant
    // and a transfer happens exactly when a grant is raised.
    assign a_ready = gnt_a;
    assign b_ready = gnt_b;
    assign grant   = gnt_a ? GNT_A : (gnt_b ? GNT_B : GNT_NONE);

`ifdef FRAMEBUF_WR_ARB_CLEAR_EN
    fb_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] fill_cnt_q, fill_cnt_d;
    logic [DATA_WIDTH-1:0] fill_data_q, fill_data_d;
    logic                  clr_done_q, clr_done_d;

    // Fill FSM state, counter, latched fill value and completion pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            fill_cnt_q  <= '0;
            fill_data_q <= '0;
            clr_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            fill_data_q <= fill_data_d;
            clr_done_q  <= clr_done_d;
        end
    end

    // Next state: clr_start beats the writers in IDLE; CLEAR walks every
    // address once and stops at all-ones. clr_done is registered with the
    // last fill write so both leave the block in the same cycle.
    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        fill_data_d = fill_data_q;
        clr_done_d  = 1'b0;
        clr_wr      = 1'b0;
        clr_wr_addr = fill_cnt_q;
        clr_wr_data = fill_data_q;
        arb_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clr_start) begin
                    state_d     = ST_CLEAR;
                    fill_cnt_d  = '0;
                    fill_data_d = clr_data;
                end else begin
                    arb_en = 1'b1;
                end
            end
            ST_CLEAR: begin
                clr_wr = 1'b1;
                if (&fill_cnt_q) begin
                    state_d    = ST_IDLE;
                    clr_done_d = 1'b1;
                end else begin
                    fill_cnt_d = fill_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign clr_busy = (state_q == ST_CLEAR);
    assign clr_done = clr_done_q;
`else
    logic unused_clr;

    assign arb_en      = 1'b1;
    assign clr_wr      = 1'b0;
    assign clr_wr_addr = '0;
    assign clr_wr_data = '0;
    assign clr_busy    = 1'b0;
    assign clr_done    = 1'b0;
    assign unused_clr  = ^{clr_start, clr_data};
`endif

    // Write-port mux: fill writes, else the granted requester; address and
    // data hold their last value when no write is issued.
    always_comb begin
        ram_we_d     = 1'b0;
        ram_addr_w_d = ram_addr_w_q;
        ram_din_d    = ram_din_q;
        if (clr_wr) begin
            ram_we_d     = 1'b1;
            ram_addr_w_d = clr_wr_addr;
            ram_din_d    = clr_wr_data;
        end else begin
            case (grant)
                GNT_A: begin
                    ram_we_d     = 1'b1;
                    ram_addr_w_d = a_addr;
                    ram_din_d    = a_data;
                end
                GNT_B: begin
                    ram_we_d     = 1'b1;
                    ram_addr_w_d = b_addr;
                    ram_din_d    = b_data;
                end
                default: begin
                end
            endcase
        end
    end

    // Registered RAM write port and read-valid delay
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_we_q     <= 1'b0;
            ram_addr_w_q <= '0;
            ram_din_q    <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            ram_we_q     <= ram_we_d;
            ram_addr_w_q <= ram_addr_w_d;
            ram_din_q    <= ram_din_d;
            rd_valid_q   <= rd_en;
        end
    end

    assign ram_we     = ram_we_q;
    assign ram_addr_w = ram_addr_w_q;
    assign ram_din    = ram_din_q;
    assign rd_valid   = rd_valid_q;
    assign ram_addr_r = rd_addr;

endmodule

// File: doc/framebuf_wr_arb.md
FRAMEBUF_WR_ARB -- requirements
Module: framebuf_wr_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, framebuffer address bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, pixel data bits.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports a_valid/a_ready  input/output  1/1  requester A write handshake.
REQ-006 SHALL have ports a_addr/a_data  input  ADDR_WIDTH/DATA_WIDTH  requester A write address/pixel.
REQ-007 SHALL have ports b_valid/b_ready, b_addr/b_data, identical to A, for requester B.
REQ-008 SHALL have port clr_start  input  1  request whole-buffer fill.
REQ-009 SHALL have port clr_data  input  DATA_WIDTH  fill value, sampled when clr_start is accepted.
REQ-010 SHALL have ports clr_busy/clr_done  output  1/1  fill in progress / one-cycle completion pulse.
REQ-011 SHALL have ports rd_en/rd_addr  input  1/ADDR_WIDTH  video scan read request.
REQ-012 SHALL have port rd_valid  output  1  RAM dout holds data for the rd_addr presented one cycle earlier.
REQ-013 SHALL have ports ram_we/ram_addr_w/ram_din/ram_addr_r  output  1/ADDR_WIDTH/DATA_WIDTH/ADDR_WIDTH  to the framebuffer RAM.

Function
REQ-014 SHALL implement FSM states IDLE and CLEAR.
REQ-015 In IDLE, SHALL grant at most one of A/B per cycle; a transfer occurs when valid and ready are both high.
REQ-016 SHALL arbitrate round-robin: when both are valid, grant the one holding priority; after any grant, priority passes to the other requester.
REQ-017 When only one requester is valid, SHALL grant it regardless of priority.
REQ-018 a_ready/b_ready SHALL be combinational from valids, priority and state, and SHALL be 0 in CLEAR.
REQ-019 A transfer accepted in cycle N SHALL appear as ram_we=1 with its addr/data in cycle N+1 (registered outputs).
REQ-020 ram_we SHALL be 0 in any cycle following one with no transfer and no clear write.
REQ-021 IDLE->CLEAR SHALL occur on clr_start=1 in IDLE; clr_start SHALL take precedence over A/B in that cycle, so no grant is issued.
REQ-022 In CLEAR, SHALL write clr_data to addresses 0..2**ADDR_WIDTH-1 ascending, one per cycle, ram_we continuously 1.
REQ-023 After the last address write is issued, SHALL return to IDLE and pulse clr_done for exactly one cycle, coincident with the last ram_we.
REQ-024 clr_busy SHALL be 1 in every cycle the FSM is in CLEAR.
REQ-025 clr_start during CLEAR SHALL be ignored; the fill SHALL not restart.
REQ-026 The fill address counter SHALL be ADDR_WIDTH bits and terminate at all-ones without wrapping.
REQ-027 ram_addr_r SHALL equal rd_addr combinationally; rd_valid SHALL be rd_en delayed one cycle; reads SHALL never stall.
REQ-028 A read and a write to the same address in one cycle SHALL be allowed; rd data is the old value, per the RAM's read-before-write behaviour.

Reset
REQ-029 On reset, SHALL enter IDLE, set priority to A, and clear ram_we, ram_addr_w, ram_din, rd_valid, clr_busy, clr_done and the fill counter to 0.
REQ-030 Reset during CLEAR SHALL abort the fill at once, with no clr_done pulse.

Configuration
REQ-031 With macro FRAMEBUF_WR_ARB_CLEAR_EN defined, SHALL include the CLEAR state and fill counter as above.
REQ-032 Without FRAMEBUF_WR_ARB_CLEAR_EN, SHALL hold clr_busy=0 and clr_done=0, ignore clr_start and clr_data, and never leave IDLE.

Structure
REQ-033 SHALL place the state enum (IDLE, CLEAR) and the grant enum (NONE, A, B) in package framebuf_wr_arb_pkg.
REQ-034 SHALL implement the two-way round-robin grant as sub-module fb_rr_arb2 (inputs: clk, reset, two requests, enable; outputs: two one-hot grants).

Verification (bench uses ADDR_WIDTH=4, DATA_WIDTH=8)
REQ-035 Reset, then A alone writes addr 3, data 0x5A -> a_ready=1; next cycle ram_we=1, ram_addr_w=3, ram_din=0x5A.
REQ-036 A and B valid for 4 consecutive cycles after reset -> grants A,B,A,B; ram_we=1 in each of the 4 following cycles.
REQ-037 clr_start=1, clr_data=0x00 while A is valid -> a_ready=0; 16 writes to addrs 0..15; clr_busy=1 for 16 cycles; clr_done pulses with addr 15; A granted next cycle.
REQ-038 clr_start re-asserted at fill address 7 -> ignored; fill ends at 15 with exactly one clr_done.
REQ-039 Reset asserted at fill address 5 -> next cycle IDLE, ram_we=0, clr_busy=0, no clr_done.
REQ-040 rd_en=1, rd_addr=9 while A writes addr 9 -> ram_addr_r=9 same cycle; rd_valid=1 next cycle; write unaffected.
